// File: rtl/wb_regfile.sv
// Writeback stage: commits ALU/mem/IO results into a 64-entry register file,
// serves two bypassed operand read ports and tracks pending writes.
module wb_regfile #(
    parameter int NREG = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  alu_addr,
    input  logic [31:0] alu_dd_val,
    input  logic [5:0]  mem_addr,
    input  logic [31:0] mem_dd_val,
    input  logic [5:0]  io_addr,
    input  logic [31:0] io_dd_val,
    input  logic [5:0]  rs_addr,
    output logic [31:0] rs_val,
    output logic        rs_rdy,
    input  logic [5:0]  rt_addr,
    output logic [31:0] rt_val,
    output logic        rt_rdy,
    input  logic        iss_vld,
    input  logic [5:0]  iss_dd,
    output logic [6:0]  pend_cnt,
    output logic        wb_conflict
);

    logic [31:0]     regs_q [NREG];
    logic [31:0]     regs_d [NREG];
    logic [NREG-1:0] pend_q, pend_d;
    logic            wb_conflict_q, wb_conflict_d;
    logic            alu_wr, io_wr, mem_wr, collide;
    logic [5:0]      rd_addr [2];
    logic [31:0]     rd_val [2];
    logic            rd_rdy [2];

    // Channel priority on a shared address is mem > io > alu.
    always_comb begin
        mem_wr  = (mem_addr != 6'd0);
        io_wr   = (io_addr != 6'd0) && (io_addr != mem_addr);
        alu_wr  = (alu_addr != 6'd0) && (alu_addr != mem_addr) && (alu_addr != io_addr);
        collide = ((io_addr != 6'd0) && (io_addr == mem_addr)) ||
                  ((alu_addr != 6'd0) && ((alu_addr == mem_addr) || (alu_addr == io_addr)));
    end

    always_comb begin
        regs_d = regs_q;
        if (alu_wr) regs_d[alu_addr] = alu_dd_val;
        if (io_wr)  regs_d[io_addr]  = io_dd_val;
        if (mem_wr) regs_d[mem_addr] = mem_dd_val;
        regs_d[0] = '0;
    end

    // A new producer issued at the same edge is younger than the returning result.
    always_comb begin
        pend_d = pend_q;
        if (alu_addr != 6'd0) pend_d[alu_addr] = 1'b0;
        if (io_addr != 6'd0)  pend_d[io_addr]  = 1'b0;
        if (mem_addr != 6'd0) pend_d[mem_addr] = 1'b0;
        if (iss_vld && (iss_dd != 6'd0)) pend_d[iss_dd] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_comb begin
        wb_conflict_d = wb_conflict_q | collide;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q        <= '{default: '0};
            pend_q        <= '0;
            wb_conflict_q <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            pend_q        <= pend_d;
            wb_conflict_q <= wb_conflict_d;
        end
    end

    assign rd_addr[0] = rs_addr;
    assign rd_addr[1] = rt_addr;

    // Later assignments override earlier ones, so mem is applied last to win.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_val[p] = regs_q[rd_addr[p]];
            rd_rdy[p] = ~pend_q[rd_addr[p]];
            if (alu_addr == rd_addr[p]) begin
                rd_val[p] = alu_dd_val;
                rd_rdy[p] = 1'b1;
            end
            if (io_addr == rd_addr[p]) begin
                rd_val[p] = io_dd_val;
                rd_rdy[p] = 1'b1;
            end
            if (mem_addr == rd_addr[p]) begin
                rd_val[p] = mem_dd_val;
                rd_rdy[p] = 1'b1;
            end
            if (rd_addr[p] == 6'd0) begin
                rd_val[p] = '0;
                rd_rdy[p] = 1'b1;
            end
        end
    end

    assign rs_val = rd_val[0];
    assign rs_rdy = rd_rdy[0];
    assign rt_val = rd_val[1];
    assign rt_rdy = rd_rdy[1];

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < NREG; i++) begin
            pend_cnt = pend_cnt + {6'd0, pend_q[i]};
        end
    end

    assign wb_conflict = wb_conflict_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: expectations are queued when stimulus is
// driven and popped against DUT outputs at the falling edge.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  alu_addr, mem_addr, io_addr, rs_addr, rt_addr, iss_dd;
    logic [31:0] alu_dd_val, mem_dd_val, io_dd_val;
    logic [31:0] rs_val, rt_val;
    logic        rs_rdy, rt_rdy, iss_vld, wb_conflict;
    logic [6:0]  pend_cnt;

    int          n_total = 0;
    int          n_pass  = 0;
    string       tag_q [$];
    logic [31:0] exp_q [$];
    logic [31:0] model [64];

    wb_regfile dut (
        .clk(clk), .rst(rst),
        .alu_addr(alu_addr), .alu_dd_val(alu_dd_val),
        .mem_addr(mem_addr), .mem_dd_val(mem_dd_val),
        .io_addr(io_addr), .io_dd_val(io_dd_val),
        .rs_addr(rs_addr), .rs_val(rs_val), .rs_rdy(rs_rdy),
        .rt_addr(rt_addr), .rt_val(rt_val), .rt_rdy(rt_rdy),
        .iss_vld(iss_vld), .iss_dd(iss_dd),
        .pend_cnt(pend_cnt), .wb_conflict(wb_conflict)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic cmp(input logic [31:0] obs);
        string       tag;
        logic [31:0] ev;
        n_total++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty observed=%h expected=<queued value>", obs);
        end else begin
            tag = tag_q.pop_front();
            ev  = exp_q.pop_front();
            assert (obs === ev) n_pass++;
            else $error("FAIL %s observed=%h expected=%h", tag, obs, ev);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        alu_addr = '0; alu_dd_val = '0;
        mem_addr = '0; mem_dd_val = '0;
        io_addr  = '0; io_dd_val  = '0;
        iss_vld  = 1'b0; iss_dd = '0;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        alu_addr = '0; alu_dd_val = '0; mem_addr = '0; mem_dd_val = '0;
        io_addr = '0; io_dd_val = '0; iss_vld = 1'b0; iss_dd = '0;
        rs_addr = '0; rt_addr = '0;

        // reset then read
        next_cycle();
        rs_addr = 6'd5; rt_addr = 6'd0;
        expect_val("rst_rs_val", 32'd0); expect_val("rst_rs_rdy", 32'd1);
        expect_val("rst_rt_val", 32'd0); expect_val("rst_rt_rdy", 32'd1);
        expect_val("rst_pend_cnt", 32'd0); expect_val("rst_conflict", 32'd0);
        sample();
        cmp(rs_val); cmp({31'd0, rs_rdy}); cmp(rt_val); cmp({31'd0, rt_rdy});
        cmp({25'd0, pend_cnt}); cmp({31'd0, wb_conflict});

        // write then read: bypass then array
        next_cycle();
        alu_addr = 6'd3; alu_dd_val = 32'h1234_5678; rs_addr = 6'd3;
        expect_val("wr_bypass", 32'h1234_5678);
        sample(); cmp(rs_val);
        next_cycle();
        alu_addr = 6'd0; alu_dd_val = 32'hFFFF_FFFF; rs_addr = 6'd3; rt_addr = 6'd5;
        expect_val("wr_array", 32'h1234_5678); expect_val("addr0_rt5", 32'd0);
        sample(); cmp(rs_val); cmp(rt_val);
        next_cycle();
        rs_addr = 6'd3; rt_addr = 6'd0;
        expect_val("addr0_nowrite_r3", 32'h1234_5678); expect_val("addr0_nowrite_r0", 32'd0);
        sample(); cmp(rs_val); cmp(rt_val);

        // scoreboard set, hold, clear by mem
        next_cycle();
        iss_vld = 1'b1; iss_dd = 6'd7; rt_addr = 6'd7;
        expect_val("sb_issue_cycle_rdy", 32'd1);
        sample(); cmp({31'd0, rt_rdy});
        for (int k = 1; k <= 2; k++) begin
            next_cycle();
            rt_addr = 6'd7;
            expect_val("sb_pending_rdy", 32'd0); expect_val("sb_pending_cnt", 32'd1);
            sample(); cmp({31'd0, rt_rdy}); cmp({25'd0, pend_cnt});
        end
        next_cycle();
        mem_addr = 6'd7; mem_dd_val = 32'hAB; rt_addr = 6'd7;
        expect_val("sb_wb_rdy", 32'd1); expect_val("sb_wb_val", 32'hAB);
        expect_val("sb_wb_cnt_pre", 32'd1);
        sample(); cmp({31'd0, rt_rdy}); cmp(rt_val); cmp({25'd0, pend_cnt});
        next_cycle();
        rt_addr = 6'd7;
        expect_val("sb_after_cnt", 32'd0); expect_val("sb_after_val", 32'hAB);
        sample(); cmp({25'd0, pend_cnt}); cmp(rt_val);

        // set/clear race on register 9
        next_cycle();
        iss_vld = 1'b1; iss_dd = 6'd9;
        next_cycle();
        iss_vld = 1'b1; iss_dd = 6'd9; io_addr = 6'd9; io_dd_val = 32'h55; rs_addr = 6'd9;
        expect_val("race_bypass_val", 32'h55); expect_val("race_bypass_rdy", 32'd1);
        sample(); cmp(rs_val); cmp({31'd0, rs_rdy});
        next_cycle();
        rs_addr = 6'd9;
        expect_val("race_val", 32'h55); expect_val("race_rdy", 32'd0);
        expect_val("race_cnt", 32'd1);
        sample(); cmp(rs_val); cmp({31'd0, rs_rdy}); cmp({25'd0, pend_cnt});
        next_cycle();
        alu_addr = 6'd9; alu_dd_val = 32'h99;
        next_cycle();
        rs_addr = 6'd9;
        expect_val("race_clear_val", 32'h99); expect_val("race_clear_cnt", 32'd0);
        sample(); cmp(rs_val); cmp({25'd0, pend_cnt});

        // three-way collision on register 4
        next_cycle();
        alu_addr = 6'd4; alu_dd_val = 32'd1; mem_addr = 6'd4; mem_dd_val = 32'd2;
        io_addr = 6'd4; io_dd_val = 32'd3; rs_addr = 6'd4;
        expect_val("coll_bypass", 32'd2); expect_val("coll_flag_pre", 32'd0);
        sample(); cmp(rs_val); cmp({31'd0, wb_conflict});
        next_cycle();
        rs_addr = 6'd4;
        expect_val("coll_array", 32'd2); expect_val("coll_flag", 32'd1);
        sample(); cmp(rs_val); cmp({31'd0, wb_conflict});
        for (int k = 0; k < 10; k++) next_cycle();
        expect_val("coll_flag_sticky", 32'd1);
        sample(); cmp({31'd0, wb_conflict});

        // pairwise priorities: io over alu, mem over io
        next_cycle();
        alu_addr = 6'd6; alu_dd_val = 32'h10; io_addr = 6'd6; io_dd_val = 32'h20;
        mem_addr = 6'd8; mem_dd_val = 32'h30;
        next_cycle();
        io_addr = 6'd8; io_dd_val = 32'h40; alu_addr = 6'd8; alu_dd_val = 32'h50;
        mem_addr = 6'd8; mem_dd_val = 32'h31; rs_addr = 6'd6; rt_addr = 6'd8;
        expect_val("prio_io_alu", 32'h20); expect_val("prio_mem_bypass", 32'h31);
        sample(); cmp(rs_val); cmp(rt_val);
        next_cycle();
        rt_addr = 6'd8;
        expect_val("prio_mem_array", 32'h31);
        sample(); cmp(rt_val);

        // register 0 never written nor pending
        next_cycle();
        iss_vld = 1'b1; iss_dd = 6'd0; alu_addr = 6'd0; alu_dd_val = 32'h5;
        rs_addr = 6'd0; rt_addr = 6'd0;
        expect_val("r0_val", 32'd0); expect_val("r0_rdy", 32'd1);
        sample(); cmp(rs_val); cmp({31'd0, rs_rdy});
        next_cycle();
        expect_val("r0_cnt", 32'd0); expect_val("r0_rt_val", 32'd0);
        sample(); cmp({25'd0, pend_cnt}); cmp(rt_val);

        // mid-operation reset
        next_cycle();
        iss_vld = 1'b1; iss_dd = 6'd11;
        next_cycle();
        expect_val("pre_rst_cnt", 32'd1);
        sample(); cmp({25'd0, pend_cnt});
        next_cycle();
        rst = 1'b1; alu_addr = 6'd12; alu_dd_val = 32'h77; iss_vld = 1'b1; iss_dd = 6'd13;
        rs_addr = 6'd3; rt_addr = 6'd12;
        expect_val("during_rst_r3", 32'h1234_5678); expect_val("during_rst_bypass", 32'h77);
        expect_val("during_rst_cnt", 32'd1);
        sample(); cmp(rs_val); cmp(rt_val); cmp({25'd0, pend_cnt});
        next_cycle();
        rs_addr = 6'd3; rt_addr = 6'd12;
        expect_val("post_rst_r3", 32'd0); expect_val("post_rst_r12", 32'd0);
        expect_val("post_rst_cnt", 32'd0); expect_val("post_rst_conflict", 32'd0);
        expect_val("post_rst_rdy", 32'd1);
        sample(); cmp(rs_val); cmp(rt_val); cmp({25'd0, pend_cnt});
        cmp({31'd0, wb_conflict}); cmp({31'd0, rt_rdy});
        next_cycle();
        alu_addr = 6'd12; alu_dd_val = 32'h77;
        next_cycle();
        rt_addr = 6'd12;
        expect_val("post_rst_commit", 32'h77);
        sample(); cmp(rt_val);

        // randomised writes across channels, then read back from the array
        for (int i = 0; i < 64; i++) model[i] = 32'd0;
        model[3] = 32'h0; model[12] = 32'h77;
        for (int i = 20; i < 30; i++) begin
            next_cycle();
            model[i] = $urandom;
            case (i % 3)
                0: begin alu_addr = 6'(i); alu_dd_val = model[i]; end
                1: begin mem_addr = 6'(i); mem_dd_val = model[i]; end
                default: begin io_addr = 6'(i); io_dd_val = model[i]; end
            endcase
        end
        for (int i = 20; i < 30; i++) begin
            next_cycle();
            rs_addr = 6'(i); rt_addr = 6'(i + 1);
            expect_val("rand_rs", model[i]); expect_val("rand_rt", model[i + 1]);
            sample(); cmp(rs_val); cmp(rt_val);
        end

        if (exp_q.size() != 0) begin
            n_total++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback and operand-supply stage for the execution unit. Consumes the three result channels produced each cycle by the execution unit (ALU, memory, I/O), each an address/value pair where address 0 means "no write". Commits them into a 64-entry register file. Supplies two combinational operand read ports with same-cycle bypass, and keeps a pending-write scoreboard so the issue logic stalls until an operand's producer has written back.

## Interface
Parameters
- NREG, 64, number of registers; address width is 6; register 0 reads as zero and is never written or marked pending

Ports
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- alu_addr  in  6  ALU result destination; 0 = no write
- alu_dd_val  in  32  ALU result value
- mem_addr  in  6  load result destination; 0 = no write
- mem_dd_val  in  32  load result value
- io_addr  in  6  IN result destination; 0 = no write
- io_dd_val  in  32  IN result value
- rs_addr  in  6  operand read port A address
- rs_val  out  32  operand A value (combinational)
- rs_rdy  out  1  operand A has no outstanding producer (combinational)
- rt_addr  in  6  operand read port B address
- rt_val  out  32  operand B value (combinational)
- rt_rdy  out  1  operand B has no outstanding producer (combinational)
- iss_vld  in  1  an instruction with a register destination issues this cycle
- iss_dd  in  6  destination of the issuing instruction
- pend_cnt  out  7  number of registers currently marked pending (combinational popcount)
- wb_conflict  out  1  sticky flag: two or more channels targeted the same nonzero address in one cycle

## Operation
- Register array `regs[1..63]`, 32 bits each; `regs[0]` is constant 0.
- Pending vector `pend[63:0]`; bit 0 is constant 0.

Write commit
- At each rising edge, every channel with a nonzero address writes its value.
- If channels collide on the same address, priority is mem > io > alu. Only the winner is written, and wb_conflict is set at that edge.
- wb_conflict stays 1 until rst.

Scoreboard
- Any channel with nonzero address A clears `pend[A]`.
- `iss_vld && iss_dd != 0` sets `pend[iss_dd]`.
- Set and clear of the same address at the same edge: set wins, because the new producer is younger.
- Setting an already-pending bit is legal and leaves it at 1. The scoreboard does not track multiple outstanding producers.

Reads, combinational, per port with address X
- X == 0: val = 0, rdy = 1.
- Else if any channel targets X this cycle: val = the priority winner's value, rdy = 1.
- Else: val = `regs[X]`, rdy = `~pend[X]`.
- rdy does not account for a same-cycle `iss_dd == X`; the issue logic sequences that itself.

Derived output
- pend_cnt = popcount(pend), range 0..63.

## Timing
- Write-to-read latency through the array is 1 cycle.
- Bypass makes the value visible in the same cycle it is presented on a channel.
- Scoreboard set takes effect after the issuing edge: rdy for iss_dd drops in the next cycle.
- rst, synchronous: clears all regs, pend, and wb_conflict at the edge. Channel inputs and iss_vld are ignored in that cycle.
- Values after the rst edge: rs_val/rt_val = 0 for any address absent bypass, rs_rdy/rt_rdy = 1, pend_cnt = 0, wb_conflict = 0.
- During rst, the combinational outputs still reflect the current (pre-reset) state plus bypass.
- rst mid-operation: outstanding pending bits are dropped. Results arriving after reset commit normally.
- No backpressure: every channel must be accepted every cycle.

## Test plan
- Reset then read: assert rst for one cycle, then read rs_addr=5, rt_addr=0 -> rs_val=0, rs_rdy=1, rt_val=0, pend_cnt=0, wb_conflict=0.
- Write then read: alu_addr=3, alu_dd_val=0x12345678 in cycle N -> rs_addr=3 gives rs_val=0x12345678 in cycle N via bypass and in cycle N+1 via the array; alu_addr=0 with value 0xFFFF_FFFF leaves all registers unchanged.
- Scoreboard: iss_vld=1, iss_dd=7 at edge N -> rt_addr=7 gives rt_rdy=0 and pend_cnt=1 from cycle N+1. mem_addr=7, mem_dd_val=0xAB in cycle N+3 -> rt_rdy=1 and rt_val=0xAB that cycle; pend_cnt=0 at N+4.
- Set/clear race: reg 9 pending; in one cycle iss_vld=1, iss_dd=9 and io_addr=9, io_dd_val=0x55 -> `regs[9]`=0x55 after the edge, `pend[9]` stays 1, rs_rdy for 9 is 0 the next cycle.
- Collision: alu_addr=mem_addr=io_addr=4 with values 1, 2, 3 -> rs_val for 4 is 2 in the same cycle; `regs[4]`=2 after the edge; wb_conflict=1 from the next cycle and still 1 after 10 idle cycles; cleared only by rst.
- Register 0: iss_vld=1, iss_dd=0 and alu_addr=0 -> pend_cnt stays 0; reading address 0 gives val 0, rdy 1.
